// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared state encoding and timeout defaults for the IIC command arbiter
package iic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int START_TO_DEF = 400;
  localparam int BUSY_TO_DEF  = 200000;

endpackage

// File: rtl/iic_rr_pick.sv
// rtl/iic_rr_pick.sv - combinational round-robin winner, search starts one past last_grant
module iic_rr_pick import iic_pkg::*; #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            any,
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_onehot
);

  always_comb begin : pick
    int cand;
    any        = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    // first hit walking upward from the slot after the previous owner wins
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!any && req[cand]) begin
        any              = 1'b1;
        win_idx          = IW'(cand);
        win_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_cmd_arbiter.sv
// rtl/iic_cmd_arbiter.sv - round-robin arbiter sharing one iic_drive among NREQ requesters
module iic_cmd_arbiter import iic_pkg::*; #(
  parameter int NREQ     = 3,
  parameter int START_TO = START_TO_DEF,
  parameter int BUSY_TO  = BUSY_TO_DEF
) (
  input  logic               clk_8m,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr_rd,
  input  logic [8*NREQ-1:0]  req_dev_addr,
  input  logic [16*NREQ-1:0] req_register,
  input  logic [8*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]    done,
  output logic               done_err,
  output logic [7:0]         done_rd_data,
  output logic [NREQ-1:0]    grant,
  output logic               start_en,
  output logic               wr_rd_flag,
  output logic [7:0]         i2c_device_addr,
  output logic [15:0]        register,
  output logic [7:0]         data_byte,
  input  logic               busy,
  input  logic               err,
  input  logic [7:0]         rd_data
);

  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TO_MAX = (START_TO > BUSY_TO) ? START_TO : BUSY_TO;
  localparam int CW     = $clog2(TO_MAX + 1);
  localparam logic [CW-1:0] START_LIM = CW'(START_TO - 1);
  localparam logic [CW-1:0] BUSY_LIM  = CW'(BUSY_TO - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;

  logic [NREQ-1:0] grant_d, done_d;
  logic            start_d, wr_rd_d, done_err_d;
  logic [7:0]      addr_d, data_d, done_rd_d;
  logic [15:0]     reg_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;

  iic_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req),
    .last_grant (last_q),
    .any        (pick_any),
    .win_idx    (pick_idx),
    .win_onehot (pick_onehot)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant;
    start_d    = start_en;
    wr_rd_d    = wr_rd_flag;
    addr_d     = i2c_device_addr;
    reg_d      = register;
    data_d     = data_byte;
    done_d     = '0;
    done_err_d = done_err;
    done_rd_d  = done_rd_data;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LAUNCH;
          grant_d = pick_onehot;
          last_d  = pick_idx;
          start_d = 1'b1;
          wr_rd_d = req_wr_rd[pick_idx];
          addr_d  = req_dev_addr[8*int'(pick_idx) +: 8];
          reg_d   = req_register[16*int'(pick_idx) +: 16];
          data_d  = req_data[8*int'(pick_idx) +: 8];
        end
      end
      ST_LAUNCH: begin
        if (busy) begin
          start_d = 1'b0;
          state_d = ST_WAIT;
        end else if (cnt_q == START_LIM) begin
          start_d    = 1'b0;
          state_d    = ST_DONE;
          done_d     = grant;
          done_err_d = 1'b1;
          done_rd_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (!busy) begin
          state_d    = ST_DONE;
          done_d     = grant;
          done_err_d = err;
          done_rd_d  = rd_data;
        end else if (cnt_q == BUSY_LIM) begin
          state_d    = ST_DONE;
          done_d     = grant;
          done_err_d = 1'b1;
          done_rd_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // each state measures its own timeout from zero
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      last_q          <= IW'(NREQ - 1);
      grant           <= '0;
      start_en        <= 1'b0;
      wr_rd_flag      <= 1'b0;
      i2c_device_addr <= '0;
      register        <= '0;
      data_byte       <= '0;
      done            <= '0;
      done_err        <= 1'b0;
      done_rd_data    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      grant           <= grant_d;
      start_en        <= start_d;
      wr_rd_flag      <= wr_rd_d;
      i2c_device_addr <= addr_d;
      register        <= reg_d;
      data_byte       <= data_d;
      done            <= done_d;
      done_err        <= done_err_d;
      done_rd_data    <= done_rd_d;
    end
  end

endmodule

// File: tb/tb_iic_cmd_arbiter.sv
// tb/tb_iic_cmd_arbiter.sv - vector table, corner sequences and randomized round-robin model for iic_cmd_arbiter
`timescale 1ns/1ps
module tb_iic_cmd_arbiter;

  localparam int N    = 3;
  localparam int S_TO = 400;
  localparam int B_TO = 600;

  logic          clk_8m = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, req_wr_rd;
  logic [8*N-1:0]  req_dev_addr, req_data;
  logic [16*N-1:0] req_register;
  logic [N-1:0]  done, grant;
  logic          done_err, start_en, wr_rd_flag;
  logic [7:0]    done_rd_data, i2c_device_addr, data_byte;
  logic [15:0]   register;
  logic          busy, err;
  logic [7:0]    rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  a_addr [N];
  logic [15:0] a_reg  [N];
  logic [7:0]  a_dat  [N];
  logic        a_wr   [N];
  int          order [$];

  typedef struct {
    logic [N-1:0] rq;
    logic [N-1:0] wr;
    logic [7:0]   addr;
    logic [15:0]  rg;
    logic [7:0]   dat;
    int           sd;
    int           bh;
    logic         e;
    logic [7:0]   rv;
    logic [N-1:0] keep;
    logic         early;
    logic [N-1:0] eg;
    logic         ee;
    logic [7:0]   erd;
  } vec_t;

  vec_t tv [7];

  iic_cmd_arbiter #(.NREQ(N), .START_TO(S_TO), .BUSY_TO(B_TO)) dut (
    .clk_8m          (clk_8m),
    .rst_n           (rst_n),
    .req             (req),
    .req_wr_rd       (req_wr_rd),
    .req_dev_addr    (req_dev_addr),
    .req_register    (req_register),
    .req_data        (req_data),
    .done            (done),
    .done_err        (done_err),
    .done_rd_data    (done_rd_data),
    .grant           (grant),
    .start_en        (start_en),
    .wr_rd_flag      (wr_rd_flag),
    .i2c_device_addr (i2c_device_addr),
    .register        (register),
    .data_byte       (data_byte),
    .busy            (busy),
    .err             (err),
    .rd_data         (rd_data)
  );

  always #5 clk_8m = ~clk_8m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_dev_addr[8*i +: 8]  = a_addr[i];
      req_register[16*i +: 16] = a_reg[i];
      req_data[8*i +: 8]      = a_dat[i];
      req_wr_rd[i]            = a_wr[i];
    end
  endtask

  task automatic set_all(input logic [7:0] ad, input logic [15:0] rg, input logic [7:0] dt, input logic [N-1:0] wr);
    for (int i = 0; i < N; i++) begin
      a_addr[i] = ad; a_reg[i] = rg; a_dat[i] = dt; a_wr[i] = wr[i];
    end
    drive_fields();
  endtask

  task automatic scramble_fields();
    for (int i = 0; i < N; i++) begin
      a_addr[i] = 8'($urandom);
      a_reg[i]  = 16'($urandom);
      a_dat[i]  = 8'($urandom);
      a_wr[i]   = 1'($urandom);
    end
    drive_fields();
  endtask

  // Round-robin as a rotating priority list: the winner moves to the back.
  task automatic model_reset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
  endtask

  function automatic int model_pick(input logic [N-1:0] mask);
    foreach (order[k]) if (mask[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_rotate(input int w);
    for (int k = 0; k < N && order[$] != w; k++) order.push_back(order.pop_front());
  endtask

  // Plays the driver side of one transaction; sd < 0 means busy never rises.
  task automatic run_txn(input int sd, input int bh, input logic e, input logic [7:0] rv,
                         input logic [N-1:0] keep, input logic early,
                         output logic [N-1:0] g, output logic [N-1:0] d, output logic de,
                         output logic [7:0] drd, output logic c_wr, output logic [7:0] c_addr,
                         output logic [15:0] c_reg, output logic [7:0] c_dat, output int st_cnt);
    int   n, phase, tb;
    logic got, stable;
    g = '0; d = '0; de = 1'b0; drd = '0; st_cnt = 0;
    c_wr = 1'b0; c_addr = '0; c_reg = '0; c_dat = '0;
    got = 1'b0; stable = 1'b1; phase = 0; tb = 0;
    n = 0;
    while (!start_en && n < 50) begin @(negedge clk_8m); n++; end
    chk("start_seen", {31'd0, start_en}, 32'd1);
    if (!start_en) return;
    g = grant; c_wr = wr_rd_flag; c_addr = i2c_device_addr; c_reg = register; c_dat = data_byte;
    scramble_fields();
    if (early) req = req & ~g;
    for (int t = 0; t < 2000 && !got; t++) begin
      if (start_en) st_cnt++;
      if (grant !== g || wr_rd_flag !== c_wr || i2c_device_addr !== c_addr ||
          register !== c_reg || data_byte !== c_dat) stable = 1'b0;
      if (done !== '0) begin
        got = 1'b1; d = done; de = done_err; drd = done_rd_data;
      end else if (phase == 0 && sd >= 0 && t >= sd) begin
        busy = 1'b1; phase = 1; tb = 0;
      end else if (phase == 1) begin
        if (tb >= bh) begin busy = 1'b0; err = e; rd_data = rv; phase = 2; end
        else tb++;
      end
      if (!got) @(negedge clk_8m);
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("cmd_stable", {31'd0, stable}, 32'd1);
    busy = 1'b0; err = 1'b0;
    req = req & ~(d & ~keep);
    @(negedge clk_8m);
    chk("done_width", 32'(done), 32'd0);
    chk("grant_clear", 32'(grant), 32'd0);
  endtask

  initial begin
    logic [N-1:0] g, d, pend, eg, keep;
    logic         de, c_wr, ewr, early;
    logic [7:0]   drd, c_addr, c_dat, eaddr, edat, rv;
    logic [15:0]  c_reg, ereg;
    int           st, w;

    tv[0] = '{3'b001, 3'b000, 8'h78, 16'h3008, 8'h82, 2, 3, 1'b0, 8'h00, 3'b000, 1'b0, 3'b001, 1'b0, 8'h00};
    tv[1] = '{3'b010, 3'b010, 8'h3c, 16'h0100, 8'h00, 0, 1, 1'b0, 8'ha5, 3'b000, 1'b0, 3'b010, 1'b0, 8'ha5};
    tv[2] = '{3'b100, 3'b000, 8'h50, 16'h1234, 8'h5a, 1, 2, 1'b1, 8'h00, 3'b000, 1'b0, 3'b100, 1'b1, 8'h00};
    tv[3] = '{3'b001, 3'b001, 8'h51, 16'h00ff, 8'h00, 3, 0, 1'b0, 8'h3c, 3'b000, 1'b0, 3'b001, 1'b0, 8'h3c};
    tv[4] = '{3'b011, 3'b000, 8'h22, 16'hbeef, 8'h11, 1, 1, 1'b0, 8'h00, 3'b000, 1'b0, 3'b010, 1'b0, 8'h00};
    tv[5] = '{3'b101, 3'b000, 8'h44, 16'h0a0b, 8'h66, 0, 4, 1'b0, 8'h00, 3'b000, 1'b0, 3'b100, 1'b0, 8'h00};
    tv[6] = '{3'b001, 3'b000, 8'h12, 16'h3456, 8'h78, 2, 2, 1'b0, 8'h00, 3'b000, 1'b1, 3'b001, 1'b0, 8'h00};

    rst_n = 1'b0; req = '0; busy = 1'b0; err = 1'b0; rd_data = '0;
    set_all(8'h0, 16'h0, 8'h0, '0);
    repeat (3) @(negedge clk_8m);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start_en", {31'd0, start_en}, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", {done_err, wr_rd_flag, done_rd_data, i2c_device_addr, data_byte}, 32'd0);
    chk("rst_register", 32'(register), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_8m);

    for (int i = 0; i < 7; i++) begin
      set_all(tv[i].addr, tv[i].rg, tv[i].dat, tv[i].wr);
      req = tv[i].rq;
      run_txn(tv[i].sd, tv[i].bh, tv[i].e, tv[i].rv, tv[i].keep, tv[i].early,
              g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
      chk($sformatf("v%0d_grant", i), 32'(g), 32'(tv[i].eg));
      chk($sformatf("v%0d_done", i), 32'(d), 32'(tv[i].eg));
      chk($sformatf("v%0d_done_err", i), {31'd0, de}, {31'd0, tv[i].ee});
      chk($sformatf("v%0d_addr", i), 32'(c_addr), 32'(tv[i].addr));
      chk($sformatf("v%0d_reg", i), 32'(c_reg), 32'(tv[i].rg));
      chk($sformatf("v%0d_data", i), 32'(c_dat), 32'(tv[i].dat));
      chk($sformatf("v%0d_wr_rd", i), {31'd0, c_wr}, {31'd0, |(tv[i].wr & tv[i].eg)});
      if ((tv[i].wr & tv[i].eg) != '0) chk($sformatf("v%0d_rd_data", i), 32'(drd), 32'(tv[i].erd));
    end
    req = '0;

    // contention from a fresh reset: all three held throughout
    rst_n = 1'b0; @(negedge clk_8m); rst_n = 1'b1; @(negedge clk_8m);
    set_all(8'h10, 16'h2020, 8'h30, 3'b000);
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 1'b0, 8'h00, 3'b111, 1'b0, g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
      eg = '0; eg[i % N] = 1'b1;
      chk($sformatf("contend%0d_grant", i), 32'(g), 32'(eg));
      if (i == 3) req = '0;
    end

    // busy never rises
    req = 3'b001;
    run_txn(-1, 0, 1'b0, 8'h00, 3'b000, 1'b0, g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
    chk("start_to_cycles", 32'(st), 32'(S_TO));
    chk("start_to_done", 32'(d), 32'b001);
    chk("start_to_err", {31'd0, de}, 32'd1);

    // busy stuck high
    req = 3'b010;
    run_txn(1, 5000, 1'b0, 8'h00, 3'b000, 1'b0, g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
    chk("busy_to_done", 32'(d), 32'b010);
    chk("busy_to_err", {31'd0, de}, 32'd1);

    req = 3'b100;
    run_txn(0, 0, 1'b0, 8'h00, 3'b000, 1'b0, g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
    chk("recover_done", 32'(d), 32'b100);
    chk("recover_err", {31'd0, de}, 32'd0);

    // reset while the driver is busy
    req = 3'b010;
    for (int n = 0; n < 50 && !start_en; n++) @(negedge clk_8m);
    busy = 1'b1;
    repeat (3) @(negedge clk_8m);
    rst_n = 1'b0;
    #1;
    chk("rstwait_grant", 32'(grant), 32'd0);
    chk("rstwait_start_en", {31'd0, start_en}, 32'd0);
    chk("rstwait_outs", {done_err, wr_rd_flag, done_rd_data, i2c_device_addr, data_byte}, 32'd0);
    chk("rstwait_register", 32'(register), 32'd0);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_8m);
      chk("rstwait_no_done", 32'(done), 32'd0);
    end
    busy = 1'b0;
    req = 3'b011;
    rst_n = 1'b1;
    run_txn(0, 1, 1'b0, 8'h00, 3'b000, 1'b0, g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
    chk("post_rst_grant", 32'(g), 32'b001);

    model_reset();
    model_rotate(0);
    pend = req;

    for (int it = 0; it < 40; it++) begin
      pend = pend | 3'($urandom_range(0, 7));
      if (pend == '0) pend = 3'b001;
      scramble_fields();
      req = pend;
      w = model_pick(pend);
      eg = '0; eg[w] = 1'b1;
      eaddr = a_addr[w]; ereg = a_reg[w]; edat = a_dat[w]; ewr = a_wr[w];
      keep  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000;
      early = ($urandom_range(0, 5) == 0);
      rv    = 8'($urandom);
      de    = ($urandom_range(0, 3) == 0);
      run_txn($urandom_range(0, 4), $urandom_range(0, 6), de, rv, keep, early,
              g, d, de, drd, c_wr, c_addr, c_reg, c_dat, st);
      chk($sformatf("r%0d_grant", it), 32'(g), 32'(eg));
      chk($sformatf("r%0d_done", it), 32'(d), 32'(eg));
      chk($sformatf("r%0d_fields", it), {c_addr, c_dat, c_reg}, {eaddr, edat, ereg});
      chk($sformatf("r%0d_wr_rd", it), {31'd0, c_wr}, {31'd0, ewr});
      if (ewr) chk($sformatf("r%0d_rd_data", it), 32'(drd), 32'(rv));
      model_rotate(w);
      pend = req;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_cmd_arbiter.md
IIC_CMD_ARBITER -- requirements
Module: iic_cmd_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (2..4).
REQ-002 Parameter START_TO, default 400, clk_8m cycles allowed for busy to rise after start_en.
REQ-003 Parameter BUSY_TO, default 200000, clk_8m cycles allowed for busy to stay high.
REQ-004 clk_8m  in  1  system clock; reset rst_n, asynchronous, active-low.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  NREQ  per-requester level request, held until its done pulse.
REQ-007 req_wr_rd  in  NREQ  per-requester op, 0 write, 1 read.
REQ-008 req_dev_addr  in  8*NREQ  per-requester device address, requester i at bits [8i+7:8i].
REQ-009 req_register  in  16*NREQ  per-requester register address.
REQ-010 req_data  in  8*NREQ  per-requester write byte.
REQ-011 done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 done_err  out  1  valid with done; 1 = driver err or timeout.
REQ-013 done_rd_data  out  8  read byte, valid with done when the op was a read.
REQ-014 grant  out  NREQ  one-hot owner of the driver, zero when idle.
REQ-015 start_en, wr_rd_flag  out  1 each  command strobe and op to iic_drive.
REQ-016 i2c_device_addr, register, data_byte  out  8/16/8  command fields to iic_drive.
REQ-017 busy, err, rd_data  in  1/1/8  status from iic_drive.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, DONE; one-hot or binary encoding.
REQ-019 IDLE: when any req bit is high, select the winner, register its fields to the driver outputs, set grant, assert start_en, enter LAUNCH on the next edge.
REQ-020 Arbitration is round-robin: search starts at index (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-021 LAUNCH: start_en stays high until busy is sampled 1, then deasserts and the FSM enters WAIT; after START_TO cycles without busy, it enters DONE with timeout.
REQ-022 WAIT: on busy sampled 0, capture err and rd_data and enter DONE; after BUSY_TO cycles, enter DONE with timeout.
REQ-023 DONE lasts exactly one cycle with done[grant]=1, done_err=err|timeout, done_rd_data captured; grant clears at exit; next state IDLE.
REQ-024 Driver command outputs are stable from the LAUNCH entry through DONE.
REQ-025 Requester fields are sampled only at grant; later changes are ignored.
REQ-026 If req of the granted requester drops mid-transaction, the transaction completes and done still pulses.
REQ-027 If a requester keeps req high after done, it re-arbitrates normally; round-robin favours others.
REQ-028 Simultaneous requests are resolved in the IDLE cycle only; new requests during LAUNCH/WAIT/DONE wait.
REQ-029 Timeout counter width is ceil(log2(max(START_TO,BUSY_TO)+1)); it clears on every state change.

Reset
REQ-030 On rst_n low: state IDLE, start_en 0, grant 0, done 0, done_err 0, done_rd_data 0, command fields 0, last_grant NREQ-1, counter 0.
REQ-031 Reset mid-transaction aborts with no done pulse; the driver is reset by the same rst_n.

Structure
REQ-032 Package iic_pkg holds the state encoding and default START_TO/BUSY_TO constants.
REQ-033 One sub-module, iic_rr_pick: combinational round-robin winner from req and last_grant.

Verification
REQ-034 Single write: req=001, addr 0x78, reg 0x3008, data 0x82 -> start_en until busy, done=001 one cycle, done_err=0.
REQ-035 Read: req=010, wr_rd=1, model returns 0xA5 -> done=010, done_rd_data=0xA5.
REQ-036 Contention: req=111 held -> grant order 001, 010, 100, 001.
REQ-037 No busy response: busy held 0 -> done pulse after START_TO (400) cycles with done_err=1.
REQ-038 Driver err=1 at busy fall -> done_err=1; next request proceeds normally.
REQ-039 rst_n low during WAIT -> all outputs 0 at once, no done; first post-reset grant goes to requester 0.
